// File: rtl/display_scan_controller.sv
// Multiplexed common-anode seven-segment scanner with frame-latched inputs,
// per-digit blank/blink/decimal point and PWM brightness. All outputs registered.
module display_scan_controller #(
  parameter int NUM_DIGITS      = 4,
  parameter int CLOCK_FREQUENCY = 100000000,
  parameter int REFRESH_RATE    = 80,
  parameter int BRIGHTNESS_BITS = 3,
  parameter int BLINK_FRAMES    = 40
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [4*NUM_DIGITS-1:0]    hex,
  input  logic [NUM_DIGITS-1:0]      dp,
  input  logic [NUM_DIGITS-1:0]      blank,
  input  logic [NUM_DIGITS-1:0]      blink,
  input  logic [BRIGHTNESS_BITS-1:0] brightness,
  output logic [NUM_DIGITS-1:0]      commons,
  output logic [6:0]                 segments,
  output logic                       dot,
  output logic                       frame_tick
);
  localparam int DIGIT_PERIOD = CLOCK_FREQUENCY / (REFRESH_RATE * NUM_DIGITS);
  localparam int SLOT_W = (DIGIT_PERIOD > 1) ? $clog2(DIGIT_PERIOD) : 1;
  localparam int DIG_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FRM_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'h0: decode = 7'h3F; 4'h1: decode = 7'h06; 4'h2: decode = 7'h5B; 4'h3: decode = 7'h4F;
      4'h4: decode = 7'h66; 4'h5: decode = 7'h6D; 4'h6: decode = 7'h7D; 4'h7: decode = 7'h07;
      4'h8: decode = 7'h7F; 4'h9: decode = 7'h6F; 4'hA: decode = 7'h77; 4'hB: decode = 7'h7C;
      4'hC: decode = 7'h39; 4'hD: decode = 7'h5E; 4'hE: decode = 7'h79; default: decode = 7'h71;
    endcase
  endfunction

  logic [SLOT_W-1:0]              slot_count;
  logic [DIG_W-1:0]               digit_index;
  logic [BRIGHTNESS_BITS-1:0]     pwm_count;
  logic [FRM_W-1:0]               frame_count;
  logic                           blink_phase;
  logic [NUM_DIGITS-1:0][3:0]     sh_hex;
  logic [NUM_DIGITS-1:0]          sh_dp, sh_blank, sh_blink;
  logic                           slot_end, frame_end, frame_wrap, lit;

  assign slot_end   = slot_count == SLOT_W'(DIGIT_PERIOD - 1);
  assign frame_end  = slot_end && (digit_index == DIG_W'(NUM_DIGITS - 1));
  assign frame_wrap = frame_count == FRM_W'(BLINK_FRAMES - 1);

  always_ff @(posedge clock) begin
    if (reset) begin
      slot_count  <= '0;
      digit_index <= '0;
      pwm_count   <= '0;
      frame_count <= '0;
      blink_phase <= 1'b0;
      sh_hex      <= '0;
      sh_dp       <= '0;
      sh_blank    <= '1;
      sh_blink    <= '0;
    end else begin
      slot_count <= slot_end ? '0 : slot_count + SLOT_W'(1);
      pwm_count  <= slot_end ? '0 : pwm_count + BRIGHTNESS_BITS'(1);
      if (slot_end)
        digit_index <= (digit_index == DIG_W'(NUM_DIGITS - 1)) ? '0 : digit_index + DIG_W'(1);
      // Latch inputs only at frame end so a frame never mixes old and new values.
      if (frame_end) begin
        sh_hex      <= hex;
        sh_dp       <= dp;
        sh_blank    <= blank;
        sh_blink    <= blink;
        frame_count <= frame_wrap ? '0 : frame_count + FRM_W'(1);
        if (frame_wrap) blink_phase <= ~blink_phase;
      end
    end
  end

  always_comb begin
    lit = 1'b0;
    lit = (pwm_count <= brightness) && !sh_blank[digit_index]
          && !(sh_blink[digit_index] && blink_phase);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      commons    <= '1;
      segments   <= 7'h7F;
      dot        <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_end;
      if (lit) begin
        commons  <= ~(NUM_DIGITS'(1) << digit_index);
        segments <= ~decode(sh_hex[digit_index]);
        dot      <= ~sh_dp[digit_index];
      end else begin
        commons  <= '1;
        segments <= 7'h7F;
        dot      <= 1'b1;
      end
    end
  end
endmodule

// File: doc/display_scan_controller.md
# display_scan_controller

Parametrised multiplexed seven-segment display driver: scans `NUM_DIGITS` common-anode digits at a fixed refresh rate and drives active-low commons, segments and decimal point. It adds per-digit blanking, per-digit blink, decimal points, PWM brightness and frame-synchronous input latching, which prevents tearing. It sits between the datapath's digit registers and the board's display pins.

## Interface
- `NUM_DIGITS`, 4: number of digits scanned; must be ≥ 2.
- `CLOCK_FREQUENCY`, 100000000: input clock frequency in Hz.
- `REFRESH_RATE`, 80: full-frame refresh rate in Hz.
- `BRIGHTNESS_BITS`, 3: width of the brightness control.
- `BLINK_FRAMES`, 40: number of frames per blink half-period; must be ≥ 1.
- `DIGIT_PERIOD` (derived, not overridable): CLOCK_FREQUENCY/(REFRESH_RATE*NUM_DIGITS), integer divide. Must be ≥ 2^BRIGHTNESS_BITS.

Ports:
- `clock`  in  1: single clock; all state on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `hex`  in  4*NUM_DIGITS: digit values; digit i = hex[4i+3:4i].
- `dp`  in  NUM_DIGITS: decimal point enable per digit (1 = on).
- `blank`  in  NUM_DIGITS: 1 = digit always dark.
- `blink`  in  NUM_DIGITS: 1 = digit dark during the blink-off phase.
- `brightness`  in  BRIGHTNESS_BITS: duty level; lit fraction = (brightness+1)/2^BRIGHTNESS_BITS.
- `commons`  out  NUM_DIGITS: active-low digit enables; at most one bit low.
- `segments`  out  7: active-low, bit6..0 = g,f,e,d,c,b,a.
- `dot`  out  1: active-low decimal point.
- `frame_tick`  out  1: one-cycle pulse on the last cycle of each frame.

## Operation
- `slot_count` counts 0..DIGIT_PERIOD-1. At DIGIT_PERIOD-1 it wraps to 0 and `digit_index` advances. `digit_index` runs 0..NUM_DIGITS-1 and wraps to 0.
- Frame end: `slot_count`==DIGIT_PERIOD-1 and `digit_index`==NUM_DIGITS-1. On that cycle:
  - Shadow registers load `hex`, `dp`, `blank` and `blink`.
  - `frame_count` increments.
  - When `frame_count` reaches BLINK_FRAMES-1, it wraps to 0 and `blink_phase` toggles.
- The display uses the shadow registers only. Input changes mid-frame have no visible effect until the next frame.
- `pwm_count` (BRIGHTNESS_BITS wide) increments every cycle, wrapping naturally, and clears to 0 when `slot_count` wraps.
- `lit` = (`pwm_count` ≤ `brightness`) and not shadow `blank`[d] and not (shadow `blink`[d] and `blink_phase`), where d = `digit_index`.
- Decode, shown active-high before inversion: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
- When `lit`:
  - `commons` = ~(1<<d).
  - `segments` = ~decode(shadow hex d).
  - `dot` = ~shadow `dp`[d].
- When not lit: `commons` all ones, `segments` 7'h7F, `dot` 1.
- Reset values:
  - Counters, `digit_index` and `blink_phase` = 0.
  - Shadow `blank` = all ones; shadow `hex`/`dp`/`blink` = 0.
  - `commons` all ones, `segments` 7'h7F, `dot` 1, `frame_tick` 0.
- Because shadow `blank` resets to all ones, the first frame after reset is dark.
- Reset asserted mid-frame: the next cycle returns to the reset state. No partial digit completes.

## Timing
- `commons`, `segments`, `dot` and `frame_tick` are registered: one cycle of latency from the internal state.
- Cycle 0 is the first edge with `reset` low, which sets `slot_count`=0.
- `frame_tick` is high on the output cycle following the frame-end internal cycle, once every NUM_DIGITS*DIGIT_PERIOD cycles.
- The digit switches in a single cycle. The last output of digit d is followed directly by the first output of digit d+1; there is no dead-time cycle.
- Blink period = 2*BLINK_FRAMES frames. The phase changes only at frame boundaries.
- Brightness is not shadowed. A change takes effect on the next cycle's `lit` evaluation.

## Test plan
Bench parameters: CLOCK_FREQUENCY=64, REFRESH_RATE=2, NUM_DIGITS=4 (DIGIT_PERIOD=8), BRIGHTNESS_BITS=2, BLINK_FRAMES=2.
- Reset hold, then release with `hex`=16'h1234, `blank`=0, `brightness`=3:
  - First 32 cycles: `commons`=4'hF, `segments`=7'h7F.
  - `frame_tick` pulses every 32 cycles.
- Second frame, steady scan:
  - 8 cycles of `commons`=1110 with `segments`=7'h19 ('4').
  - Then 1101 with 7'h30, 1011 with 7'h24, 0111 with 7'h79.
  - `dp`=4'b0010 gives `dot`=0 only while `commons`=1101.
- `brightness`=0: within each 8-cycle slot, the digit is lit only in cycles 0 and 4 (`pwm_count`==0) and dark in the other 6.
- Change `hex` to 16'hABCD mid-frame: the remaining digits of that frame still show 1234; the next frame shows D, C, b, A (7'h21, 7'h46, 7'h03, 7'h08).
- `blink`=4'b0100: digit 2 alternates lit for 2 frames and dark for 2 frames. Other digits are unaffected. `blank`[0]=1 keeps digit 0 dark in every frame.
- Assert `reset` for one cycle mid-slot of digit 2: the next output is all dark, `frame_tick`=0, and the scan restarts at digit 0 with a dark first frame.
